// File: rtl/cond_logic.sv
// cond_logic: conditional-execution unit for the single-cycle ARMv4 datapath.
// Holds the architectural NZCV flags and evaluates Cond against them. It
// qualifies the decoder's PC, register and memory write strobes with the
// condition result. Optional saturating counters track taken PC writes and
// instructions squashed by a false condition.
//
// Optional feature macro: COND_PERF_CNT_EN
//   defined   -> BranchCount / SkipCount registers are built
//   undefined -> both counter outputs are tied to 0
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   en                  instruction valid / advance (0 = stall)
//   Cond                instruction condition field [31:28]
//   ALUFlags            {N,Z,C,V} from the ALU this cycle
//   FlagW               [1] loads N,Z ; [0] loads C,V
//   PCS, RegW, MemW     raw decoder write requests
//   NoWrite             compare/test register-write suppression
//   PCSrc, RegWrite,
//   MemWrite            condition-qualified enables (combinational)
//   CondEx              condition passed (combinational from stored flags)
//   Flags               registered {N,Z,C,V}
//   BranchCount         taken PC writes (saturating)
//   SkipCount           condition-failed instructions (saturating)
module cond_logic #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0] flags_q;
  logic       n_f, z_f, c_f, v_f;

  assign Flags = flags_q;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition decode against the stored flags only; ALUFlags is never bypassed.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

  // Qualified enables; a stall forces all of them low.
  assign PCSrc    = en & CondEx & PCS;
  assign RegWrite = en & CondEx & RegW & ~NoWrite;
  assign MemWrite = en & CondEx & MemW;

  // Flag register: N,Z and C,V halves load independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (en && CondEx) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] skip_cnt_q;

  // Saturating event counters; they hold at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      skip_cnt_q   <= '0;
    end else if (en) begin
      if (PCSrc && (branch_cnt_q != CNT_MAX))
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (!CondEx && (skip_cnt_q != CNT_MAX))
        skip_cnt_q <= skip_cnt_q + CNT_W'(1);
    end
  end

  assign BranchCount = branch_cnt_q;
  assign SkipCount   = skip_cnt_q;
`else
  assign BranchCount = '0;
  assign SkipCount   = '0;
`endif

endmodule
